// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO pair.
// Shift-add multiply and restoring divide share one 2*WIDTH working register.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] inBack,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_div;
  logic               r_sa;
  logic               r_sb;
  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH-1:0] r_p;

  logic               w_sgn;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_mul_nx;
  logic [2*WIDTH-1:0] w_div_nx;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;

  assign w_sgn   = ~op[0];
  assign w_abs_a = (w_sgn && opA[WIDTH-1]) ? -opA : opA;
  assign w_abs_b = (w_sgn && opB[WIDTH-1]) ? -opB : opB;

  // Multiply: add multiplicand into the upper half on LSB, then shift right.
  assign w_sum    = {1'b0, r_p[2*WIDTH-1:WIDTH]}
                  + (r_p[0] ? {1'b0, r_m} : '0);
  assign w_mul_nx = {w_sum, r_p[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, lower half shifts the
  // dividend out and the quotient in.
  assign w_trial  = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_diff   = w_trial - {1'b0, r_m};
  assign w_ge     = ~w_diff[WIDTH];
  assign w_div_nx = {w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0],
                     r_p[WIDTH-2:0], w_ge};

  assign w_prod = (r_sa ^ r_sb) ? -w_mul_nx : w_mul_nx;
  assign w_q    = (r_sa ^ r_sb) ? -w_div_nx[WIDTH-1:0]
                                : w_div_nx[WIDTH-1:0];
  assign w_r    = r_sa ? -w_div_nx[2*WIDTH-1:WIDTH]
                       : w_div_nx[2*WIDTH-1:WIDTH];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_div       <= 1'b0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_m         <= '0;
      r_p         <= '0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (hi_we) hi <= inBack;
          if (lo_we) lo <= inBack;
          if (start) begin
            r_div <= op[1];
            r_sa  <= w_sgn & opA[WIDTH-1];
            r_sb  <= w_sgn & opB[WIDTH-1];
            r_cnt <= '0;
            if (op[1]) begin
              r_m <= w_abs_b;
              r_p <= {{WIDTH{1'b0}}, w_abs_a};
            end else begin
              r_m <= w_abs_a;
              r_p <= {{WIDTH{1'b0}}, w_abs_b};
            end
            if (op[1] && opB == '0) begin
              r_state     <= S_DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
            end else begin
              r_state <= S_RUN;
              busy    <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_p   <= r_div ? w_div_nx : w_mul_nx;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            if (r_div) begin
              hi <= w_r;
              lo <= w_q;
            end else begin
              hi <= w_prod[2*WIDTH-1:WIDTH];
              lo <= w_prod[WIDTH-1:0];
            end
          end
        end
        S_DONE: begin
          if (hi_we) hi <= inBack;
          if (lo_we) lo <= inBack;
          r_state     <= S_IDLE;
          done        <= 1'b0;
          div_by_zero <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, div-by-zero,
// ignored inputs during RUN and mid-operation reset.
module tb_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] inBack = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  int lat;
  int bcnt;
  int zcnt;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  muldiv_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .op(op),
    .opA(opA), .opB(opB), .hi_we(hi_we), .lo_we(lo_we),
    .inBack(inBack), .hi(hi), .lo(lo), .busy(busy),
    .done(done), .div_by_zero(div_by_zero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    @(negedge Clk);
    op = o; opA = a; opB = b; start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    opA = 32'h1234_5678;
    opB = 32'h0BAD_F00D;
  endtask

  // Waits for done; lat counts cycles after the start edge.
  task automatic wait_done(output int l, output int bc, output int zc);
    l = 0; bc = 0; zc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      if (busy) bc++;
      if (done) begin
        l = i;
        zc = int'(div_by_zero);
        break;
      end
    end
    if (l == 0) l = 99;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    launch(o, a, b);
    wait_done(lat, bcnt, zcnt);
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_hilo"}, {hi, lo}, {ehi, elo});
    @(negedge Clk);
    chk({tag, "_done_off"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("reset_state", {hi, lo}, 64'd0);
    chk("reset_flags", {61'd0, busy, done, div_by_zero}, 64'd0);

    launch(MULTU, 32'h5F, 32'h28D);
    wait_done(lat, bcnt, zcnt);
    chk("multu_lat", 64'(lat), 64'd33);
    chk("multu_busy", 64'(bcnt), 64'd32);
    chk("multu_dbz", 64'(zcnt), 64'd0);
    chk("multu_hilo", {hi, lo}, 64'h0000_0000_0000_F253);
    @(negedge Clk);
    chk("multu_pulse", {62'd0, done, busy}, 64'd0);

    run_op("mult_neg", MULT, 32'hFFFF_FFFF, 32'h0653_0025,
           32'hFFFF_FFFF, 32'hF9AC_FFDB);
    run_op("multu_big", MULTU, 32'hFFFF_FFFF, 32'h0653_0025,
           32'h0653_0024, 32'hF9AC_FFDB);
    run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'h2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", DIVU, 32'h28D, 32'h5F, 32'h53, 32'h6);
    run_op("div_wrap", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, 32'h8000_0000);
    run_op("div_rem_sign", DIV, 32'h7, 32'hFFFF_FFFE,
           32'h1, 32'hFFFF_FFFD);

    // Preload HI/LO, then divide by zero.
    @(negedge Clk);
    hi_we = 1'b1; inBack = 32'h11;
    @(negedge Clk);
    hi_we = 1'b0; lo_we = 1'b1; inBack = 32'h22;
    @(negedge Clk);
    lo_we = 1'b0;
    chk("mthi_mtlo", {hi, lo}, {32'h11, 32'h22});
    launch(DIVU, 32'h99, 32'h0);
    wait_done(lat, bcnt, zcnt);
    chk("dbz_lat", 64'(lat), 64'd1);
    chk("dbz_flag", 64'(zcnt), 64'd1);
    chk("dbz_busy", 64'(bcnt), 64'd0);
    chk("dbz_hilo", {hi, lo}, {32'h11, 32'h22});
    @(negedge Clk);
    chk("dbz_clear", {61'd0, busy, done, div_by_zero}, 64'd0);

    // start and hi_we during RUN are ignored.
    launch(MULTU, 32'h5F, 32'h28D);
    repeat (5) @(negedge Clk);
    start = 1'b1; op = DIV; opA = 32'h1; opB = 32'h1;
    hi_we = 1'b1; inBack = 32'hDEAD_BEEF;
    @(negedge Clk);
    start = 1'b0; hi_we = 1'b0;
    wait_done(lat, bcnt, zcnt);
    chk("ignore_lat", 64'(lat), 64'd27);
    chk("ignore_hilo", {hi, lo}, 64'h0000_0000_0000_F253);
    @(negedge Clk);

    // MTLO in DONE is honoured.
    launch(MULTU, 32'h3, 32'h4);
    wait_done(lat, bcnt, zcnt);
    lo_we = 1'b1; inBack = 32'hCAFE_0001;
    @(negedge Clk);
    lo_we = 1'b0;
    chk("mtlo_in_done", {hi, lo}, {32'h0, 32'hCAFE_0001});

    // Reset mid-RUN discards the operation.
    launch(MULT, 32'hFFFF_FFFF, 32'h0653_0025);
    repeat (10) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("midrst_hilo", {hi, lo}, 64'd0);
    chk("midrst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    wait_done(lat, bcnt, zcnt);
    chk("midrst_no_done", 64'(lat), 64'd99);
    run_op("after_rst", DIVU, 32'h28D, 32'h5F, 32'h53, 32'h6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with the architectural HI/LO registers for the MIPS CPU.
- Sits directly downstream of the register file. Operands come from the register file's outa/outb read ports.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the 64-bit result in HI/LO for later reads.
- Also accepts direct HI/LO writes (MTHI/MTLO) from the writeback bus.

Parameters:
- WIDTH, 32, operand and HI/LO width. The iteration count equals WIDTH.

Ports:
- Clk  input  1  system clock; all state changes on rising edge
- Reset  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- opA  input  WIDTH  rs operand (register file outa); multiplicand or dividend
- opB  input  WIDTH  rt operand (register file outb); multiplier or divisor
- hi_we  input  1  MTHI: write inBack into HI
- lo_we  input  1  MTLO: write inBack into LO
- inBack  input  WIDTH  data for MTHI/MTLO
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when a result (or a divide-by-zero abort) is committed
- div_by_zero  output  1  high together with done when DIV/DIVU had opB==0

Behaviour:
- Reset, synchronous:
  - state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - Iteration counter and working registers cleared.
  - Reset takes effect even mid-RUN; the in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: latch op, opA, opB.
  - Signed ops latch |opA| and |opB| plus the sign flags.
  - DIV/DIVU with opB==0: go to DONE, div_by_zero=1, HI/LO unchanged.
  - Otherwise: go to RUN with count=0 and busy=1 from the next cycle.
- RUN:
  - One iteration per cycle, WIDTH iterations total.
  - Multiply: shift-add on a 2*WIDTH-bit product.
  - Divide: restoring, one quotient bit per cycle.
  - On the edge where count==WIDTH-1, go to DONE and commit the result to HI/LO at that same edge.
  - busy=1 throughout RUN. start is ignored.
  - hi_we/lo_we are ignored in RUN and do not alter the pending result.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Next edge: go to IDLE. done=0 and div_by_zero=0.
  - start is ignored in DONE.
  - hi_we/lo_we are honoured in DONE.
- Latency and throughput:
  - start edge to done high: WIDTH+1 cycles (33).
  - Divide-by-zero: done high 1 cycle after the start edge.
  - Back-to-back operations: a new start is accepted no earlier than 2 cycles after done rises.
- Result rules:
  - MULT/MULTU: {HI,LO} = full 2*WIDTH-bit product. MULT negates the product when the operand signs differ.
  - DIV/DIVU: LO = quotient, truncated toward zero; HI = remainder.
  - DIV: quotient negated if the signs differ. Remainder takes the sign of the dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
- MTHI/MTLO in IDLE/DONE:
  - Register loads inBack at the edge.
  - hi_we and lo_we together load both registers.
  - hi_we/lo_we on the same edge as start in IDLE: the write takes effect and the operation starts. The final result overwrites it.
- Stability: operand inputs may change after the start edge without affecting the operation.

Test Plan:
- Reset 1 for one edge, release; MULTU opA=0x5F opB=0x28D -> busy 1 for 32 cycles; done pulses at start+33; hi=0x00000000, lo=0x0000F253.
- MULT opA=0xFFFFFFFF opB=0x06530025 -> hi=0xFFFFFFFF, lo=0xF9ACFFDB. MULTU with the same operands -> hi=0x06530024, lo=0xF9ACFFDB.
- DIV opA=0xFFFFFFF9 (-7) opB=0x2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU opA=0x28D opB=0x5F -> lo=0x6, hi=0x53.
- DIVU opB=0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> done and div_by_zero high 1 cycle after start; hi/lo stay 0x11/0x22; busy never asserts.
- During RUN of MULTU 0x5F*0x28D: pulse start with different operands and pulse hi_we with inBack=0xDEADBEEF -> both ignored; final hi=0, lo=0xF253.
- Start MULT, assert Reset at RUN cycle 10 -> next cycle hi=lo=0, busy=0, done=0, state IDLE; no done pulse follows. A new start after reset completes correctly.
